bin_to_gray_counter: RTL and testbench

Binary-to-Gray encoder, the inverse of the team's Gray-to-binary converter. It has two parts:
- A clocked up/down Gray-code counter with load. It is used as a pointer generator for clock-domain-crossing FIFOs, and its Gray output feeds the Gray-to-binary decoder on the far side.
- A registered one-shot converter path with valid qualification, for encoding arbitrary binary words with a fixed 1-cycle latency.

---
 rtl/bin_to_gray_counter.sv | 118 +++++++++++
 tb/tb_bin_to_gray_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_gray_counter.sv
// Binary-to-Gray encoder: up/down Gray counter with load (CDC pointer
// generator) plus an independent registered 1-cycle binary-to-Gray converter.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         counter step enable
//   up_down    step direction, 1 = increment, 0 = decrement
//   load       synchronous counter load from load_bin (wins over en)
//   load_bin   binary value to load
//   bin_count  registered binary counter value
//   gray_count registered Gray encoding of bin_count (same edge, no skew)
//   gray_next  combinational Gray value the counter takes at the next edge
//   wrap       registered one-cycle pulse when a step wraps around
//   in_valid   converter input qualifier
//   in_bin     converter binary input
//   out_valid  converter output qualifier (in_valid delayed one cycle)
//   out_gray   Gray encoding of the last accepted in_bin
module bin_to_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_count,
    output logic [WIDTH-1:0] gray_count,
    output logic [WIDTH-1:0] gray_next,
    output logic             wrap,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_gray
);

    function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_gray;

    logic [WIDTH-1:0] w_bin_inc;
    logic [WIDTH-1:0] w_bin_dec;
    logic [WIDTH-1:0] w_bin_step;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_step_wraps;
    logic [WIDTH-1:0] w_gray_load;
    logic [WIDTH-1:0] w_gray_step;

    // Step datapath; arithmetic is naturally modulo 2^WIDTH.
    assign w_bin_inc    = r_bin + WIDTH'(1);
    assign w_bin_dec    = r_bin - WIDTH'(1);
    assign w_bin_step   = up_down ? w_bin_inc : w_bin_dec;
    assign w_at_max     = &r_bin;
    assign w_at_min     = ~|r_bin;
    assign w_step_wraps = up_down ? w_at_max : w_at_min;

    assign w_gray_load  = enc(load_bin);
    assign w_gray_step  = enc(w_bin_step);

    // Look-ahead of the counter's next Gray value, same priority as the
    // register update so it always matches gray_count one edge later.
    always_comb begin
        w_gray_next_mux: begin
            gray_next = r_gray;
            if (rst)
                gray_next = '0;
            else if (load)
                gray_next = w_gray_load;
            else if (en)
                gray_next = w_gray_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_bin  <= load_bin;
            r_gray <= w_gray_load;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_bin  <= w_bin_step;
            r_gray <= w_gray_step;
            r_wrap <= w_step_wraps;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Converter path: out_gray only updates on accepted words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_gray  <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid)
                r_out_gray <= enc(in_bin);
        end
    end

    assign bin_count  = r_bin;
    assign gray_count = r_gray;
    assign wrap       = r_wrap;
    assign out_valid  = r_out_valid;
    assign out_gray   = r_out_gray;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Self-checking bench for bin_to_gray_counter (WIDTH=4).
// Scoreboard of expected outputs plus directed constant checks.
module tb_bin_to_gray_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] bin_count;
    logic [W-1:0] gray_count;
    logic [W-1:0] gray_next;
    logic         wrap;
    logic         in_valid;
    logic [W-1:0] in_bin;
    logic         out_valid;
    logic [W-1:0] out_gray;

    bin_to_gray_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_down   (up_down),
        .load      (load),
        .load_bin  (load_bin),
        .bin_count (bin_count),
        .gray_count(gray_count),
        .gray_next (gray_next),
        .wrap      (wrap),
        .in_valid  (in_valid),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_gray  (out_gray)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] bin;
        logic [W-1:0] gray;
        logic         wrap;
        logic         ov;
        logic [W-1:0] og;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_bin  = '0;
    logic         m_wrap = 1'b0;
    logic         m_ov   = 1'b0;
    logic [W-1:0] m_og   = '0;

    function automatic logic [W-1:0] g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check gray_next, push expectation,
    // then pop and compare registered outputs just after posedge.
    task automatic cycle(input logic r, input logic ld, input logic e,
                         input logic ud, input logic [W-1:0] lb,
                         input logic iv, input logic [W-1:0] ib);
        logic [W-1:0] gn;
        logic [W-1:0] prev_g;
        exp_t x;
        exp_t y;
        @(negedge clk);
        rst = r; load = ld; en = e; up_down = ud;
        load_bin = lb; in_valid = iv; in_bin = ib;
        #1;
        if (r)
            gn = '0;
        else if (ld)
            gn = g(lb);
        else if (e)
            gn = ud ? g(m_bin + 4'd1) : g(m_bin - 4'd1);
        else
            gn = g(m_bin);
        chk("gray_next", 32'(gray_next), 32'(gn));
        prev_g = gray_count;
        if (r) begin
            m_bin = '0; m_wrap = 1'b0;
        end else if (ld) begin
            m_bin = lb; m_wrap = 1'b0;
        end else if (e) begin
            if (ud) begin
                m_wrap = (m_bin == 4'hF); m_bin = m_bin + 4'd1;
            end else begin
                m_wrap = (m_bin == 4'h0); m_bin = m_bin - 4'd1;
            end
        end else begin
            m_wrap = 1'b0;
        end
        if (r) begin
            m_ov = 1'b0; m_og = '0;
        end else begin
            m_ov = iv;
            if (iv) m_og = g(ib);
        end
        x.bin = m_bin; x.gray = g(m_bin); x.wrap = m_wrap;
        x.ov = m_ov; x.og = m_og;
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 32'(q.size()), 32'd1);
        end else begin
            y = q.pop_front();
            chk("bin_count",  32'(bin_count),  32'(y.bin));
            chk("gray_count", 32'(gray_count), 32'(y.gray));
            chk("wrap",       32'(wrap),       32'(y.wrap));
            chk("out_valid",  32'(out_valid),  32'(y.ov));
            chk("out_gray",   32'(out_gray),   32'(y.og));
        end
        if (!r && !ld && e)
            chk("hamming1", 32'($countones(prev_g ^ gray_count)), 32'd1);
    endtask

    logic [W-1:0] up_seq [17];

    initial begin
        up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                   4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                   4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
        rst = 1'b1; load = 1'b0; en = 1'b0; up_down = 1'b1;
        load_bin = '0; in_valid = 1'b0; in_bin = '0;

        // Reset with other controls active.
        cycle(1, 1, 1, 1, 4'hA, 1, 4'h5);
        cycle(1, 0, 1, 1, 4'h0, 1, 4'h3);
        chk("rst_bin",  32'(bin_count),  32'd0);
        chk("rst_gray", 32'(gray_count), 32'd0);
        chk("rst_ov",   32'(out_valid),  32'd0);
        chk("rst_og",   32'(out_gray),   32'd0);

        // Count up through wrap.
        for (int i = 0; i < 17; i++) begin
            cycle(0, 0, 1, 1, 4'h0, 0, 4'h0);
            chk($sformatf("up_gray%0d", i), 32'(gray_count), 32'(up_seq[i]));
            chk($sformatf("up_wrap%0d", i), 32'(wrap), 32'(i == 15));
        end

        // Count down from reset.
        cycle(1, 0, 0, 1, 4'h0, 0, 4'h0);
        cycle(0, 0, 1, 0, 4'h0, 0, 4'h0);
        chk("dn_bin0",  32'(bin_count),  32'hF);
        chk("dn_gray0", 32'(gray_count), 32'b1000);
        chk("dn_wrap0", 32'(wrap),       32'd1);
        cycle(0, 0, 1, 0, 4'h0, 0, 4'h0);
        chk("dn_bin1",  32'(bin_count),  32'hE);
        chk("dn_gray1", 32'(gray_count), 32'b1001);
        chk("dn_wrap1", 32'(wrap),       32'd0);

        // Load beats enable.
        cycle(0, 1, 1, 1, 4'b0110, 0, 4'h0);
        chk("ld_bin",  32'(bin_count),  32'b0110);
        chk("ld_gray", 32'(gray_count), 32'b0101);
        chk("ld_wrap", 32'(wrap),       32'd0);

        // Converter.
        cycle(0, 0, 0, 1, 4'h0, 1, 4'b1010);
        chk("cv_og0", 32'(out_gray), 32'b1111);
        chk("cv_ov0", 32'(out_valid), 32'd1);
        cycle(0, 0, 0, 1, 4'h0, 1, 4'b0111);
        chk("cv_og1", 32'(out_gray), 32'b0100);
        cycle(0, 0, 0, 1, 4'h0, 0, 4'b1111);
        chk("cv_ov2", 32'(out_valid), 32'd0);
        chk("cv_og2", 32'(out_gray),  32'b0100);

        // Reset mid-operation.
        cycle(1, 0, 0, 1, 4'h0, 0, 4'h0);
        for (int i = 0; i < 5; i++)
            cycle(0, 0, 1, 1, 4'h0, 1, 4'(i + 3));
        chk("mid_gray", 32'(gray_count), 32'b0111);
        cycle(1, 0, 1, 1, 4'h0, 1, 4'h9);
        chk("mid_rst_bin",  32'(bin_count),  32'd0);
        chk("mid_rst_gray", 32'(gray_count), 32'd0);
        chk("mid_rst_ov",   32'(out_valid),  32'd0);
        chk("mid_rst_og",   32'(out_gray),   32'd0);
        cycle(0, 0, 1, 1, 4'h0, 0, 4'h0);
        chk("mid_resume", 32'(gray_count), 32'b0001);

        // Hold at gray 0110 (bin 0100).
        cycle(0, 1, 0, 1, 4'b0100, 0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 4'hC, 0, 4'h0);
            chk("hold_gray", 32'(gray_count), 32'b0110);
            chk("hold_next", 32'(gray_next),  32'b0110);
        end

        // Random mixed traffic.
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
